// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register in-flight write tracking for the pipelined CPU.
// Decode issues instructions with a destination and two sources. Write-back
// retires destination writes. A small saturating counter per register stalls
// issue on RAW hazards and on counter overflow.
//
// Ports:
//   Clk, Rst_n       clock, asynchronous active-low reset
//   Issue_Valid      decode presents an instruction
//   Issue_WrEn       instruction writes Issue_Dest
//   Issue_Dest       destination register
//   Issue_Src1/2     source registers
//   Issue_Ready      instruction may issue this cycle (combinational)
//   Wb_Valid         write-back retires a write to Wb_Dest this cycle
//   Wb_Dest          register being written back
//   Flush            synchronous clear of all pending state
//   Busy_Mask        bit i set when register i has outstanding writes (registered)
//   Pending          total outstanding writes (registered)
//   Err              sticky: write-back to a register with nothing pending
module reg_scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned CNT_W    = 2
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Issue_Valid,
    input  logic                Issue_WrEn,
    input  logic [ADDR_W-1:0]   Issue_Dest,
    input  logic [ADDR_W-1:0]   Issue_Src1,
    input  logic [ADDR_W-1:0]   Issue_Src2,
    output logic                Issue_Ready,
    input  logic                Wb_Valid,
    input  logic [ADDR_W-1:0]   Wb_Dest,
    input  logic                Flush,
    output logic [NUM_REGS-1:0] Busy_Mask,
    output logic [ADDR_W+1:0]   Pending,
    output logic                Err
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [ADDR_W+1:0]   pending_q, pending_d;
    logic                err_q, err_d;

    logic [CNT_W-1:0] src1_cnt, src2_cnt, dest_cnt, wb_cnt;
    logic             src1_blocked, src2_blocked, dest_blocked;
    logic             inc, dec, err_set;

    // Addresses beyond NUM_REGS read as untracked (count 0).
    always_comb begin
        src1_cnt = (32'(Issue_Src1) < NUM_REGS) ? cnt_q[Issue_Src1] : '0;
        src2_cnt = (32'(Issue_Src2) < NUM_REGS) ? cnt_q[Issue_Src2] : '0;
        dest_cnt = (32'(Issue_Dest) < NUM_REGS) ? cnt_q[Issue_Dest] : '0;
        wb_cnt   = (32'(Wb_Dest) < NUM_REGS)    ? cnt_q[Wb_Dest]    : '0;
    end

    always_comb begin
        // A source whose last outstanding write retires this cycle is bypassed.
        src1_blocked = (Issue_Src1 != '0) && (src1_cnt != '0) &&
                       !((src1_cnt == CntOne) && Wb_Valid && (Wb_Dest == Issue_Src1));
        src2_blocked = (Issue_Src2 != '0) && (src2_cnt != '0) &&
                       !((src2_cnt == CntOne) && Wb_Valid && (Wb_Dest == Issue_Src2));
        // A full counter accepts another write only if one retires this cycle.
        dest_blocked = Issue_WrEn && (Issue_Dest != '0) && (dest_cnt == CntMax) &&
                       !(Wb_Valid && (Wb_Dest == Issue_Dest));
        Issue_Ready  = !Flush && !src1_blocked && !src2_blocked && !dest_blocked;

        inc     = Issue_Valid && Issue_Ready && Issue_WrEn && (Issue_Dest != '0);
        dec     = Wb_Valid && (Wb_Dest != '0) && (wb_cnt != '0);
        err_set = !Flush && Wb_Valid && (Wb_Dest != '0) && (wb_cnt == '0);
    end

    always_comb begin
        busy_d = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (i != 0) begin
                if (inc && (32'(Issue_Dest) == i) && !(dec && (32'(Wb_Dest) == i))) begin
                    cnt_d[i] = cnt_q[i] + CntOne;
                end else if (dec && (32'(Wb_Dest) == i) &&
                             !(inc && (32'(Issue_Dest) == i))) begin
                    cnt_d[i] = cnt_q[i] - CntOne;
                end
            end
            if (Flush) begin
                cnt_d[i] = '0;
            end
            busy_d[i] = (cnt_d[i] != '0);
        end

        pending_d = pending_q;
        if (Flush) begin
            pending_d = '0;
        end else if (inc && !dec) begin
            pending_d = pending_q + 1'b1;
        end else if (dec && !inc) begin
            pending_d = pending_q - 1'b1;
        end

        err_d = err_q | err_set;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
            busy_q    <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            busy_q    <= busy_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign Busy_Mask = busy_q;
    assign Pending   = pending_q;
    assign Err       = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

    localparam int NR = 32;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b1;
    logic        Issue_Valid = 1'b0;
    logic        Issue_WrEn = 1'b0;
    logic [4:0]  Issue_Dest = '0;
    logic [4:0]  Issue_Src1 = '0;
    logic [4:0]  Issue_Src2 = '0;
    logic        Issue_Ready;
    logic        Wb_Valid = 1'b0;
    logic [4:0]  Wb_Dest = '0;
    logic        Flush = 1'b0;
    logic [31:0] Busy_Mask;
    logic [6:0]  Pending;
    logic        Err;

    int n_chk = 0;
    int n_pass = 0;
    int m_cnt[NR];
    bit m_err = 1'b0;

    reg_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .CNT_W(2)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Issue_Valid(Issue_Valid), .Issue_WrEn(Issue_WrEn), .Issue_Dest(Issue_Dest),
        .Issue_Src1(Issue_Src1), .Issue_Src2(Issue_Src2), .Issue_Ready(Issue_Ready),
        .Wb_Valid(Wb_Valid), .Wb_Dest(Wb_Dest), .Flush(Flush),
        .Busy_Mask(Busy_Mask), .Pending(Pending), .Err(Err)
    );

    always #5 Clk = ~Clk;

    // Reference model: plain integer counts per register.
    function automatic bit m_ready();
        int s[2];
        int d;
        s[0] = int'(Issue_Src1);
        s[1] = int'(Issue_Src2);
        d = int'(Issue_Dest);
        if (Flush) return 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (s[k] != 0 && m_cnt[s[k]] != 0 &&
                !(m_cnt[s[k]] == 1 && Wb_Valid && int'(Wb_Dest) == s[k])) return 1'b0;
        end
        if (Issue_WrEn && d != 0 && m_cnt[d] == 3 && !(Wb_Valid && int'(Wb_Dest) == d))
            return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] m = '0;
        for (int i = 1; i < NR; i++) if (m_cnt[i] != 0) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [6:0] m_pending();
        int s = 0;
        for (int i = 1; i < NR; i++) s += m_cnt[i];
        return 7'(s);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    endtask

    task automatic drive(input bit v, input bit we, input int d, input int s1, input int s2,
                         input bit wv, input int wd, input bit fl);
        Issue_Valid = v;
        Issue_WrEn  = we;
        Issue_Dest  = 5'(d);
        Issue_Src1  = 5'(s1);
        Issue_Src2  = 5'(s2);
        Wb_Valid    = wv;
        Wb_Dest     = 5'(wd);
        Flush       = fl;
    endtask

    // Advance one clock; the model consumes the inputs present before the edge.
    task automatic tick();
        bit fire, wv, we, fl;
        int d, wd;
        fire = Issue_Valid && m_ready();
        we = Issue_WrEn;
        d = int'(Issue_Dest);
        wv = Wb_Valid;
        wd = int'(Wb_Dest);
        fl = Flush;
        @(posedge Clk);
        if (fl) begin
            m_clear();
        end else begin
            if (wv && wd != 0) begin
                if (m_cnt[wd] != 0) m_cnt[wd]--;
                else m_err = 1'b1;
            end
            if (fire && we && d != 0) m_cnt[d]++;
        end
        #1;
    endtask

    task automatic test_reset();
        m_clear();
        #1 Rst_n = 1'b0;
        #2;
        n_chk++;
        if (Busy_Mask !== 32'h0) $display("FAIL reset_busy: got %h want 0", Busy_Mask);
        else n_pass++;
        n_chk++;
        if (Pending !== 7'd0) $display("FAIL reset_pending: got %0d want 0", Pending);
        else n_pass++;
        n_chk++;
        if (Err !== 1'b0) $display("FAIL reset_err: got %b want 0", Err);
        else n_pass++;
        n_chk++;
        if (Issue_Ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", Issue_Ready);
        else n_pass++;
        @(negedge Clk) Rst_n = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_bypass();
        drive(1, 1, 5, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (Busy_Mask !== 32'h0000_0020) $display("FAIL bypass_busy: got %h want 00000020", Busy_Mask);
        else n_pass++;
        n_chk++;
        if (Pending !== 7'd1) $display("FAIL bypass_pending: got %0d want 1", Pending);
        else n_pass++;
        drive(1, 0, 0, 5, 0, 0, 0, 0);
        #1;
        n_chk++;
        if (Issue_Ready !== 1'b0) $display("FAIL bypass_blocked: got %b want 0", Issue_Ready);
        else n_pass++;
        drive(1, 0, 0, 5, 0, 1, 5, 0);
        #1;
        n_chk++;
        if (Issue_Ready !== 1'b1) $display("FAIL bypass_ready: got %b want 1", Issue_Ready);
        else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (Busy_Mask !== 32'h0 || Pending !== 7'd0)
            $display("FAIL bypass_drain: got busy=%h pend=%0d want 0/0", Busy_Mask, Pending);
        else n_pass++;
    endtask

    task automatic test_dest_zero();
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0);
            #1;
            n_chk++;
            if (Issue_Ready !== 1'b1) $display("FAIL dest0_ready: got %b want 1", Issue_Ready);
            else n_pass++;
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (Busy_Mask !== 32'h0 || Pending !== 7'd0)
            $display("FAIL dest0_state: got busy=%h pend=%0d want 0/0", Busy_Mask, Pending);
        else n_pass++;
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 7, 0, 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (Pending !== 7'd3 || Busy_Mask !== 32'h0000_0080)
            $display("FAIL sat_fill: got pend=%0d busy=%h want 3/00000080", Pending, Busy_Mask);
        else n_pass++;
        drive(1, 1, 7, 0, 0, 0, 0, 0);
        #1;
        n_chk++;
        if (Issue_Ready !== 1'b0) $display("FAIL sat_blocked: got %b want 0", Issue_Ready);
        else n_pass++;
        tick();
        drive(1, 1, 7, 0, 0, 1, 7, 0);
        #1;
        n_chk++;
        if (Issue_Ready !== 1'b1) $display("FAIL sat_wb_ready: got %b want 1", Issue_Ready);
        else n_pass++;
        tick();
        drive(1, 1, 7, 0, 0, 0, 0, 0);
        #1;
        n_chk++;
        if (Pending !== 7'd3 || Issue_Ready !== 1'b0)
            $display("FAIL sat_hold: got pend=%0d ready=%b want 3/0", Pending, Issue_Ready);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 1, 7, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (Pending !== 7'd0 || Err !== 1'b0)
            $display("FAIL sat_drain: got pend=%0d err=%b want 0/0", Pending, Err);
        else n_pass++;
    endtask

    task automatic test_same_reg();
        drive(1, 1, 9, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 9, 0, 0, 1, 9, 0);
        #1;
        n_chk++;
        if (Issue_Ready !== 1'b1) $display("FAIL same_ready: got %b want 1", Issue_Ready);
        else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (Pending !== 7'd1 || Busy_Mask !== 32'h0000_0200 || Err !== 1'b0)
            $display("FAIL same_state: got pend=%0d busy=%h err=%b want 1/00000200/0",
                     Pending, Busy_Mask, Err);
        else n_pass++;
        drive(0, 0, 0, 0, 0, 1, 9, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_err();
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        n_chk++;
        if (Err !== 1'b0) $display("FAIL err_wb0: got %b want 0", Err);
        else n_pass++;
        drive(0, 0, 0, 0, 0, 1, 12, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (Err !== 1'b1 || Pending !== 7'd0)
            $display("FAIL err_set: got err=%b pend=%0d want 1/0", Err, Pending);
        else n_pass++;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (Err !== 1'b1) $display("FAIL err_flush: got %b want 1", Err);
        else n_pass++;
        #2 Rst_n = 1'b0;
        #1;
        n_chk++;
        if (Err !== 1'b0) $display("FAIL err_reset: got %b want 0", Err);
        else n_pass++;
        m_err = 1'b0;
        m_clear();
        @(negedge Clk) Rst_n = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_flush();
        drive(1, 1, 3, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 4, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 31, 0, 0, 0, 0, 0);
        tick();
        n_chk++;
        if (Busy_Mask !== 32'h8000_0018 || Pending !== 7'd3)
            $display("FAIL flush_fill: got busy=%h pend=%0d want 80000018/3", Busy_Mask, Pending);
        else n_pass++;
        drive(1, 1, 5, 0, 0, 0, 0, 1);
        #1;
        n_chk++;
        if (Issue_Ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", Issue_Ready);
        else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (Busy_Mask !== 32'h0 || Pending !== 7'd0)
            $display("FAIL flush_clear: got busy=%h pend=%0d want 0/0", Busy_Mask, Pending);
        else n_pass++;
        drive(1, 1, 6, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 8, 6, 0, 0, 0, 0);
        #2 Rst_n = 1'b0;
        #1;
        n_chk++;
        if (Busy_Mask !== 32'h0 || Pending !== 7'd0 || Err !== 1'b0 || Issue_Ready !== 1'b1)
            $display("FAIL async_reset: got busy=%h pend=%0d err=%b ready=%b want 0/0/0/1",
                     Busy_Mask, Pending, Err, Issue_Ready);
        else n_pass++;
        m_clear();
        m_err = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge Clk) Rst_n = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    function automatic int pick();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, 31));
        return int'($urandom_range(0, 7));
    endfunction

    task automatic test_random();
        bit v, we, wv, fl;
        int d, s1, s2, wd;
        for (int c = 0; c < 400; c++) begin
            v  = ($urandom_range(0, 3) != 0);
            we = ($urandom_range(0, 3) != 0);
            d  = pick();
            s1 = pick();
            s2 = pick();
            fl = ($urandom_range(0, 39) == 0);
            wv = !fl && ($urandom_range(0, 1) == 1);
            wd = pick();
            if ($urandom_range(0, 9) != 0) begin
                for (int i = 1; i < NR; i++) begin
                    if (m_cnt[i] != 0 && $urandom_range(0, 1) == 0) wd = i;
                end
            end
            drive(v, we, d, s1, s2, wv, wd, fl);
            #1;
            n_chk++;
            if (Issue_Ready !== m_ready())
                $display("FAIL rand_ready c=%0d: got %b want %b", c, Issue_Ready, m_ready());
            else n_pass++;
            tick();
            n_chk++;
            if (Busy_Mask !== m_mask() || Pending !== m_pending() || Err !== m_err)
                $display("FAIL rand_state c=%0d: got busy=%h pend=%0d err=%b want %h/%0d/%b",
                         c, Busy_Mask, Pending, Err, m_mask(), m_pending(), m_err);
            else n_pass++;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_dest_zero();
        test_saturate();
        test_same_reg();
        test_err();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-destination scoreboard for the pipelined CPU. It sits at the consuming end of the 5-bit destination-register path: the decode stage presents the selected write address (rt or rd) as it issues, and the write-back stage presents the same address when the result is written. The block tracks in-flight writes per register, blocks issue of instructions whose sources are still pending, and exposes a busy mask for the forwarding/hazard logic.

## Interface

Parameters:
- NUM_REGS, 32, architectural registers tracked; register 0 is never tracked.
- ADDR_W, 5, register address width.
- CNT_W, 2, per-register in-flight counter width; maximum outstanding writes per register is 2^CNT_W-1 = 3.

Ports:
- Clk  input  1  single clock; all state updates on the rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- Issue_Valid  input  1  decode presents an instruction.
- Issue_WrEn  input  1  instruction writes a register.
- Issue_Dest  input  ADDR_W  destination register (mux-selected rt/rd).
- Issue_Src1, Issue_Src2  input  ADDR_W  source registers.
- Issue_Ready  output  1  instruction may issue this cycle (combinational).
- Wb_Valid  input  1  write-back retires a register write this cycle.
- Wb_Dest  input  ADDR_W  register being written back.
- Flush  input  1  synchronous clear of all pending state.
- Busy_Mask  output  NUM_REGS  bit i = 1 when register i has a nonzero counter (registered).
- Pending  output  ADDR_W+2  total outstanding writes across all registers (registered).
- Err  output  1  sticky error: write-back to a register with no pending write.

## Operation

- Per-register counter cnt[i], i = 1..NUM_REGS-1; cnt[0] is constant 0.
- Issue fire = Issue_Valid && Issue_Ready.
- Source Sx is blocked when Sx != 0 and cnt[Sx] != 0, except bypass: not blocked when cnt[Sx] == 1 and Wb_Valid && Wb_Dest == Sx in the same cycle.
- Destination is blocked when Issue_WrEn && Issue_Dest != 0 && cnt[Issue_Dest] == 3, unless Wb_Valid && Wb_Dest == Issue_Dest in the same cycle.
- Issue_Ready = !Flush && !src1_blocked && !src2_blocked && !dest_blocked.
- Increment: on fire with Issue_WrEn && Issue_Dest != 0, cnt[Issue_Dest] += 1.
- Decrement: on Wb_Valid with Wb_Dest != 0 and cnt[Wb_Dest] != 0, cnt[Wb_Dest] -= 1.
- Increment and decrement on the same register in the same cycle leave cnt unchanged.
- Write-back to register 0 is ignored, with no error.
- Write-back to a nonzero register with cnt == 0 leaves cnt at 0 and sets Err. Err clears only on reset.
- Pending tracks the sum of all cnt, updated by the same net +1/0/-1 rule. Maximum value is 31*3 = 93, which fits ADDR_W+2 = 7 bits.
- Flush has priority over issue and write-back: all cnt, Busy_Mask and Pending go to 0 next edge. Err is not cleared by Flush.

## Timing

- Reset (Rst_n low, asynchronous): all cnt = 0, Busy_Mask = 0, Pending = 0, Err = 0. Issue_Ready = 1 while Rst_n is low and Flush is 0.
- Counter, Busy_Mask and Pending updates appear one cycle after the fire or write-back edge.
- Issue_Ready is combinational from current counters plus same-cycle Wb_Valid/Wb_Dest/Flush. There is no registered path, so a dependent instruction issues in the same cycle as its producer's write-back.
- Issue and write-back are independent and may both occur every cycle.
- Reset assertion mid-operation discards all pending state immediately. Release is synchronous to the Clk edge as seen by downstream logic.

## Test plan

- Reset, then issue Dest=5 (WrEn=1); next cycle Busy_Mask=0x00000020, Pending=1. Issue Src1=5 -> Issue_Ready=0. Wb_Dest=5 in that cycle -> Issue_Ready=1 (bypass), and after the edge Busy_Mask=0, Pending=0.
- Issue Dest=0 three times -> Busy_Mask stays 0, Pending=0. Src1=0 is never blocked.
- Issue Dest=7 three times -> cnt[7]=3, Pending=3. A fourth issue to Dest=7 -> Issue_Ready=0. Same request with Wb_Dest=7 in the same cycle -> fires, and cnt[7] stays 3.
- Simultaneous issue Dest=9 and Wb_Dest=9 with cnt[9]=1 -> cnt[9] stays 1, Pending unchanged, Err=0.
- Wb_Dest=12 with cnt[12]=0 -> Err=1 next cycle. Err remains 1 after Flush, and clears only on Rst_n low.
- Pending writes to regs 3, 4 and 31; assert Flush -> Issue_Ready=0 that cycle. Next cycle Busy_Mask=0, Pending=0. Drop Rst_n mid-stream -> outputs clear without waiting for a clock edge.
